// File: rtl/regfile_writeback_queue.sv
// Merges the in-order pipeline writeback and a buffered long-latency result stream
// onto the single register-file write port, and tracks outstanding destinations.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              pipe_wen,
    input  logic [4:0]        pipe_wsel,
    input  logic [WORD_W-1:0] pipe_wdat,
    input  logic              lu_issue,
    input  logic [4:0]        lu_issue_sel,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [4:0]        lu_sel,
    input  logic [WORD_W-1:0] lu_dat,
    output logic              rf_wen,
    output logic [4:0]        rf_wsel,
    output logic [WORD_W-1:0] rf_wdat,
    output logic [31:0]       busy_mask,
    output logic              full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        sel_mem_q [DEPTH];
    logic [WORD_W-1:0] dat_mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:1]       busy_q, busy_d;

    logic              empty;
    logic              pipe_act;
    logic              push;
    logic              pop;
    logic [4:0]        head_sel;
    logic [WORD_W-1:0] head_dat;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign lu_ready  = !full;
    assign head_sel  = sel_mem_q[rd_ptr_q];
    assign head_dat  = dat_mem_q[rd_ptr_q];
    // A pipeline write to x0 is not a real write, so it must not block the drain.
    assign pipe_act  = pipe_wen && (pipe_wsel != 5'd0);
    assign pop       = !pipe_act && !empty;
    // Results for x0 complete the handshake but are never stored.
    assign push      = lu_valid && lu_ready && (lu_sel != 5'd0);
    assign busy_mask = {busy_q, 1'b0};

    always_comb begin
        rf_wen  = 1'b0;
        rf_wsel = 5'd0;
        rf_wdat = '0;
        if (pipe_act) begin
            rf_wen  = 1'b1;
            rf_wsel = pipe_wsel;
            rf_wdat = pipe_wdat;
        end else if (!empty) begin
            rf_wen  = 1'b1;
            rf_wsel = head_sel;
            rf_wdat = head_dat;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A re-issue landing on the same edge as the pop of that register keeps it busy.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_d[gi] = (lu_issue && (lu_issue_sel == 5'(gi)))
                              || (busy_q[gi] && !(pop && (head_sel == 5'(gi))));
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem_q[wr_ptr_q] <= lu_sel;
            dat_mem_q[wr_ptr_q] <= lu_dat;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scenario tasks drive the write-back queue; a scoreboard of accepted results
// is drained and compared against every register-file write.
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] dat;
    } ent_t;

    logic        clk;
    logic        nrst;
    logic        pipe_wen;
    logic [4:0]  pipe_wsel;
    logic [31:0] pipe_wdat;
    logic        lu_issue;
    logic [4:0]  lu_issue_sel;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_sel;
    logic [31:0] lu_dat;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [31:0] busy_mask;
    logic        full;

    int          tests = 0;
    int          fails = 0;
    ent_t        sb[$];
    logic [31:0] mbusy;
    bit          m_pop;
    bit          m_push;
    logic        e_wen;
    logic [4:0]  e_sel;
    logic [31:0] e_dat;

    regfile_writeback_queue #(.DEPTH(DEPTH), .WORD_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
        .lu_issue(lu_issue), .lu_issue_sel(lu_issue_sel),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_sel(lu_sel), .lu_dat(lu_dat),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .busy_mask(busy_mask), .full(full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: queue of accepted results plus busy bits.
    initial begin
        mbusy = '0;
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                sb.delete();
                mbusy = '0;
            end else begin
                m_pop  = !(pipe_wen && pipe_wsel != 5'd0) && (sb.size() != 0);
                m_push = lu_valid && (lu_sel != 5'd0) && (sb.size() < DEPTH);
                if (m_pop) begin
                    mbusy[sb[0].sel] = 1'b0;
                    void'(sb.pop_front());
                end
                if (lu_issue && lu_issue_sel != 5'd0) mbusy[lu_issue_sel] = 1'b1;
                if (m_push) sb.push_back('{lu_sel, lu_dat});
            end
        end
    end

    // Monitor: every cycle, compare the write port and status against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (pipe_wen && pipe_wsel != 5'd0) begin
                    e_wen = 1'b1; e_sel = pipe_wsel; e_dat = pipe_wdat;
                end else if (sb.size() != 0) begin
                    e_wen = 1'b1; e_sel = sb[0].sel; e_dat = sb[0].dat;
                end else begin
                    e_wen = 1'b0; e_sel = 5'd0; e_dat = 32'd0;
                end
                tests++;
                if ({rf_wen, rf_wsel, rf_wdat} !== {e_wen, e_sel, e_dat}) begin
                    fails++;
                    $display("FAIL mon_rf t=%0t: got wen=%0b sel=%0d dat=%h, want wen=%0b sel=%0d dat=%h",
                             $time, rf_wen, rf_wsel, rf_wdat, e_wen, e_sel, e_dat);
                end
                tests++;
                if (busy_mask !== mbusy) begin
                    fails++;
                    $display("FAIL mon_busy t=%0t: got %h want %h", $time, busy_mask, mbusy);
                end
                tests++;
                if ({full, lu_ready} !== {sb.size() == DEPTH, sb.size() < DEPTH}) begin
                    fails++;
                    $display("FAIL mon_full t=%0t: got full=%0b ready=%0b, want entries=%0d",
                             $time, full, lu_ready, sb.size());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wen = 0; pipe_wsel = 0; pipe_wdat = 0;
        lu_issue = 0; lu_issue_sel = 0;
        lu_valid = 0; lu_sel = 0; lu_dat = 0;
    endtask

    task automatic test_reset();
        nrst = 0;
        idle_inputs();
        #3;
        tests++;
        if ({full, lu_ready, busy_mask, rf_wen} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got full=%0b ready=%0b busy=%h wen=%0b, want 0 1 0 0",
                     full, lu_ready, busy_mask, rf_wen);
        end
        repeat (2) @(negedge clk);
        #1 nrst = 1;
        cyc();
        $display("[TB] reset: released");
    endtask

    task automatic test_basic_drain();
        lu_issue = 1; lu_issue_sel = 5;
        cyc();
        lu_issue = 0;
        tests++;
        if (busy_mask[5] !== 1'b1) begin
            fails++; $display("FAIL drain_busy_set: got %0b want 1", busy_mask[5]);
        end
        lu_valid = 1; lu_sel = 5; lu_dat = 32'hDEADBEEF;
        cyc();
        lu_valid = 0;
        @(negedge clk);
        tests++;
        if ({rf_wen, rf_wsel, rf_wdat, busy_mask[5]} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            fails++;
            $display("FAIL drain_write: got wen=%0b sel=%0d dat=%h busy5=%0b, want 1 5 deadbeef 1",
                     rf_wen, rf_wsel, rf_wdat, busy_mask[5]);
        end
        cyc();
        tests++;
        if (busy_mask[5] !== 1'b0) begin
            fails++; $display("FAIL drain_busy_clr: got %0b want 0", busy_mask[5]);
        end
        $display("[TB] basic_drain: x5 written");
    endtask

    task automatic test_priority();
        lu_issue = 1; lu_issue_sel = 7;
        cyc();
        lu_issue = 0;
        lu_valid = 1; lu_sel = 7; lu_dat = 32'h11;
        pipe_wen = 1; pipe_wsel = 3; pipe_wdat = 32'h21;
        cyc();
        lu_valid = 0; pipe_wdat = 32'h22;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({rf_wsel, rf_wdat, busy_mask[7]} !== {5'd3, 32'h22, 1'b1}) begin
                fails++;
                $display("FAIL prio_pipe%0d: got sel=%0d dat=%h busy7=%0b, want 3 22 1",
                         i, rf_wsel, rf_wdat, busy_mask[7]);
            end
            cyc();
        end
        pipe_wen = 0;
        @(negedge clk);
        tests++;
        if ({rf_wen, rf_wsel, rf_wdat, busy_mask[7]} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
            fails++;
            $display("FAIL prio_fifo: got wen=%0b sel=%0d dat=%h busy7=%0b, want 1 7 11 1",
                     rf_wen, rf_wsel, rf_wdat, busy_mask[7]);
        end
        cyc();
        tests++;
        if (busy_mask[7] !== 1'b0) begin
            fails++; $display("FAIL prio_busy_clr: got %0b want 0", busy_mask[7]);
        end
        $display("[TB] priority: x3 x3 then x7");
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            lu_issue = 1; lu_issue_sel = 5'(i);
            cyc();
        end
        lu_issue = 0;
        pipe_wen = 1; pipe_wsel = 10; pipe_wdat = 32'hA;
        for (int i = 1; i <= 4; i++) begin
            lu_valid = 1; lu_sel = 5'(i); lu_dat = 32'h100 + i;
            cyc();
        end
        tests++;
        if ({full, lu_ready} !== 2'b10) begin
            fails++; $display("FAIL full_flag: got full=%0b ready=%0b want 1 0", full, lu_ready);
        end
        lu_sel = 6; lu_dat = 32'h666;
        cyc();
        lu_valid = 0;
        pipe_wen = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tests++;
            if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'(i), 32'h100 + i}) begin
                fails++;
                $display("FAIL full_drain%0d: got wen=%0b sel=%0d dat=%h, want 1 %0d %h",
                         i, rf_wen, rf_wsel, rf_wdat, i, 32'h100 + i);
            end
            cyc();
            if (i == 1) begin
                tests++;
                if (lu_ready !== 1'b1) begin
                    fails++; $display("FAIL full_ready_back: got %0b want 1", lu_ready);
                end
            end
        end
        @(negedge clk);
        tests++;
        if (rf_wen !== 1'b0) begin
            fails++; $display("FAIL full_no_fifth: got wen=%0b sel=%0d want wen 0", rf_wen, rf_wsel);
        end
        $display("[TB] full: drained x1..x4, fifth rejected");
    endtask

    task automatic test_x0();
        lu_valid = 1; lu_sel = 0; lu_dat = 32'h55;
        #1;
        tests++;
        if (lu_ready !== 1'b1) begin
            fails++; $display("FAIL x0_ready: got %0b want 1", lu_ready);
        end
        cyc();
        lu_valid = 0;
        @(negedge clk);
        tests++;
        if ({rf_wen, full, lu_ready} !== 3'b001) begin
            fails++;
            $display("FAIL x0_no_push: got wen=%0b full=%0b ready=%0b want 0 0 1", rf_wen, full, lu_ready);
        end
        cyc();
        lu_issue = 1; lu_issue_sel = 8;
        lu_valid = 1; lu_sel = 8; lu_dat = 32'h88;
        pipe_wen = 1; pipe_wsel = 12; pipe_wdat = 32'hC;
        cyc();
        lu_issue = 0; lu_valid = 0;
        pipe_wsel = 0; pipe_wdat = 32'h99;
        @(negedge clk);
        tests++;
        if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd8, 32'h88}) begin
            fails++;
            $display("FAIL x0_pipe_drain: got wen=%0b sel=%0d dat=%h want 1 8 88", rf_wen, rf_wsel, rf_wdat);
        end
        cyc();
        pipe_wen = 0;
        tests++;
        if (busy_mask[8] !== 1'b0) begin
            fails++; $display("FAIL x0_busy8: got %0b want 0", busy_mask[8]);
        end
        $display("[TB] x0: dropped result, pipe x0 did not block drain");
    endtask

    task automatic test_race();
        lu_issue = 1; lu_issue_sel = 9;
        cyc();
        lu_issue = 0;
        lu_valid = 1; lu_sel = 9; lu_dat = 32'h909;
        pipe_wen = 1; pipe_wsel = 13; pipe_wdat = 32'hD;
        cyc();
        lu_valid = 0; pipe_wen = 0;
        lu_issue = 1; lu_issue_sel = 9;
        @(negedge clk);
        tests++;
        if ({rf_wen, rf_wsel} !== {1'b1, 5'd9}) begin
            fails++; $display("FAIL race_pop: got wen=%0b sel=%0d want 1 9", rf_wen, rf_wsel);
        end
        cyc();
        lu_issue = 0;
        tests++;
        if (busy_mask[9] !== 1'b1) begin
            fails++; $display("FAIL race_set_wins: got %0b want 1", busy_mask[9]);
        end
        lu_valid = 1; lu_sel = 9; lu_dat = 32'h919;
        cyc();
        lu_valid = 0;
        cyc();
        tests++;
        if (busy_mask[9] !== 1'b0) begin
            fails++; $display("FAIL race_final_clr: got %0b want 0", busy_mask[9]);
        end
        $display("[TB] race: set beat clear on x9");
    endtask

    task automatic test_reset_mid();
        pipe_wen = 1; pipe_wsel = 14; pipe_wdat = 32'hE;
        for (int i = 0; i < 3; i++) begin
            lu_issue = 1; lu_issue_sel = 5'(20 + i);
            lu_valid = 1; lu_sel = 5'(20 + i); lu_dat = 32'(i);
            cyc();
        end
        idle_inputs();
        #2 nrst = 0;
        #1;
        tests++;
        if ({full, lu_ready, busy_mask, rf_wen} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL midreset_async: got full=%0b ready=%0b busy=%h wen=%0b, want 0 1 0 0",
                     full, lu_ready, busy_mask, rf_wen);
        end
        @(negedge clk);
        #1 nrst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (rf_wen !== 1'b0) begin
                fails++; $display("FAIL midreset_stale%0d: got wen=%0b sel=%0d want wen 0", i, rf_wen, rf_wsel);
            end
        end
        $display("[TB] reset_mid: queue flushed");
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_priority();
        test_full();
        test_x0();
        test_race();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side initiator for the integer register file. It merges two result producers into the file's single write port: the in-order pipeline writeback and a long-latency unit (divider or load miss) whose results arrive out of order. Long-latency results are buffered in a small FIFO and drained whenever the pipeline is not writing. A per-register busy scoreboard tells decode which destinations still have results outstanding.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- WORD_W, 32, data width; matches word_t

Ports:
- clk  in  1  core clock; all state updates on rising edge
- nrst  in  1  asynchronous, active-low reset
- pipe_wen  in  1  pipeline writeback valid this cycle
- pipe_wsel  in  5  pipeline destination register
- pipe_wdat  in  WORD_W  pipeline write data
- lu_issue  in  1  long-latency op issued this cycle; reserves lu_issue_sel
- lu_issue_sel  in  5  destination reserved by the issue
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  queue accepts a result; = !full
- lu_sel  in  5  result destination
- lu_dat  in  WORD_W  result data
- rf_wen  out  1  register file write enable
- rf_wsel  out  5  register file write select
- rf_wdat  out  WORD_W  register file write data
- busy_mask  out  32  bit i set = result for x_i outstanding; bit 0 always 0
- full  out  1  FIFO holds DEPTH entries

## Operation
- State: FIFO storage of {sel, dat}, rd/wr pointers, count (clog2(DEPTH)+1 bits), busy[31:1].
- Enqueue: on lu_valid && lu_ready, push {lu_sel, lu_dat} at the rising edge. If lu_sel == 0, the handshake completes but nothing is pushed.
- Write-port arbitration, combinational, fixed priority:
  - Pipeline first: pipe_wen && pipe_wsel != 0 → rf_wen=1, rf_wsel=pipe_wsel, rf_wdat=pipe_wdat. The FIFO does not pop.
  - Otherwise, if the FIFO is non-empty: drive the head entry and pop at the edge.
  - Otherwise: rf_wen=0, rf_wsel=0, rf_wdat=0.
- Pipeline write with pipe_wsel == 0 counts as no pipeline write, so the FIFO may drain that cycle.
- Scoreboard:
  - lu_issue && lu_issue_sel != 0 sets busy[lu_issue_sel].
  - A FIFO pop clears busy[head sel].
  - Same register set and cleared in the same cycle: set wins.
  - Pipeline writes never change busy. Preventing a pipeline write to a busy register is decode's job (it stalls on busy_mask). If such a write occurs anyway, it is performed.
- Push and pop in the same cycle: count unchanged, both pointers advance. A push is never accepted when full, even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. FIFO order is strictly preserved.

## Timing
- Reset (async assert, sync-safe deassert): count=0, pointers=0, busy=0. Outputs while in reset: lu_ready=1, full=0, busy_mask=0. rf_wen=0 unless pipe_wen is driven.
- rf_* are combinational from FIFO head and pipe_* inputs. They are stable before the falling edge, at which the register file latches them.
- Latency:
  - Result accepted at edge N → earliest rf_wen in cycle N+1, busy bit clear after edge N+1.
  - No same-cycle bypass of lu_* to rf_*.
- Issue at edge N → busy_mask bit visible in cycle N+1.
- lu_ready/full reflect the registered count only: combinational from state, not from the current pop.
- Continuous pipe_wen with non-zero pipe_wsel starves the FIFO indefinitely. This is acceptable: the pipeline stalls on busy_mask, so pipe_wen eventually drops.

## Test plan
- Reset mid-operation: fill 3 entries, assert nrst=0 asynchronously → full=0, lu_ready=1, busy_mask=0 immediately. After release no stale writes occur; rf_wen=0 with pipe_wen=0.
- Basic drain: issue x5, then a result {5, 0xDEADBEEF} at edge N with pipe idle → cycle N+1: rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF. busy_mask[5] is 1 through cycle N+1 and 0 in N+2.
- Priority: FIFO holds {7, 0x11}, pipe writes {3, 0x22} for 2 cycles → rf writes x3 twice, then x7 in the third cycle. busy[7] clears only after the x7 write.
- Full/backpressure: issue x1..x4, push 4 results while pipe_wen=1 → full=1, lu_ready=0. A 5th offered result is not accepted. Dropping pipe_wen drains x1, x2, x3, x4 in order; lu_ready returns after the first pop.
- x0 handling: result with lu_sel=0 is accepted (lu_ready stays 1), with no push and no rf write. A pipe write to x0 coincident with a non-empty FIFO still drains the head that cycle.
- Set-vs-clear race: x9 pending at head; re-issue x9 in the same cycle it pops → busy_mask[9] remains 1 afterward.
